// File: rtl/uart_echo_pkg.sv
// Shared types and ASCII constants for the UART echo engine.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO  = 2'b00,
    MODE_UPPER = 2'b01,
    MODE_LINE  = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_e;

  localparam logic [7:0] ASCII_a        = 8'h61;
  localparam logic [7:0] ASCII_z        = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;
  localparam logic [7:0] ASCII_CR       = 8'h0D;

endpackage

// File: rtl/uart_echo_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is taken only
// alongside a pop. The head word is presented combinationally on rdata_o.
module uart_echo_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observable through a non-empty pointer pair.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_echo_engine.sv
// Echo controller between UART core RX and TX: capture/ack, optional case
// transform, buffered FIFO, line-mode holding, paced TX pushes, drop counting.
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16,
  parameter int          CNT_W     = 16,
  parameter int unsigned LINE_TERM = 32'h0D,
  localparam int         LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ack,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_push,
  input  logic              tx_full,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [DATA_W-1:0] TERM_WORD = DATA_W'(LINE_TERM);

  mode_e             mode_s;
  logic              rx_ack_q;
  logic [DATA_W-1:0] cap_q, upper_word, wr_word, head;
  logic              wr_req, wr_accept, drop, pop, drain;
  logic              push_prev_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [LVL_W-1:0]  term_cnt_q, term_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              fifo_full, fifo_empty;
  logic              wr_is_term, pop_is_term;

  assign mode_s = mode_e'(mode);

  generate
    if (DATA_W == 8) begin : g_case
      assign upper_word = (cap_q >= ASCII_a && cap_q <= ASCII_z) ? cap_q - ASCII_CASE_OFS : cap_q;
    end else begin : g_nocase
      assign upper_word = cap_q;
    end
  endgenerate

  assign wr_word   = (mode_s == MODE_UPPER) ? upper_word : cap_q;
  assign wr_req    = rx_ack_q && (mode_s != MODE_MUTE);
  assign pop       = !fifo_empty && !tx_full && !push_prev_q && drain;
  assign wr_accept = wr_req && (!fifo_full || pop);
  assign drop      = wr_req && fifo_full && !pop;

  always_comb begin
    drain = 1'b1;
    if (mode_s == MODE_LINE) drain = (term_cnt_q != '0) || fifo_full;
  end

  // term_cnt mirrors the number of terminators currently held in the FIFO.
  assign wr_is_term  = wr_accept && (wr_word == TERM_WORD);
  assign pop_is_term = pop && (head == TERM_WORD);

  always_comb begin
    term_cnt_d = term_cnt_q;
    if (wr_is_term && !pop_is_term)      term_cnt_d = term_cnt_q + LVL_W'(1);
    else if (pop_is_term && !wr_is_term) term_cnt_d = term_cnt_q - LVL_W'(1);
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_ack_q    <= 1'b0;
      cap_q       <= '0;
      push_prev_q <= 1'b0;
      tx_data_q   <= '0;
      term_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      rx_ack_q    <= rx_valid && !rx_ack_q;
      if (rx_valid && !rx_ack_q) cap_q <= rx_data;
      push_prev_q <= pop;
      if (pop) tx_data_q <= head;
      term_cnt_q  <= term_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  uart_echo_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (wr_accept),
    .wdata_i (wr_word),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // The popped word goes out in the same cycle; tx_data otherwise holds the last push.
  assign rx_ack   = rx_ack_q;
  assign tx_push  = pop;
  assign tx_data  = pop ? head : tx_data_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Randomised bench for uart_echo_engine: a queue-level reference model predicts
// every TX word and its cycle; a monitor compares DUT pushes and status outputs.
module tb_uart_echo_engine;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_full = 1'b0;
  logic          rx_ack, tx_push;
  logic [7:0]    tx_data;
  logic [LW-1:0] fifo_level;
  logic [15:0]   drop_cnt;
  logic          rx_ack2, tx_push2;
  logic [7:0]    tx_data2;
  logic [LW-1:0] fifo_level2;
  logic [1:0]    drop_cnt2;

  uart_echo_engine dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  uart_echo_engine #(.CNT_W(2)) dut_sat (
    .clk(clk), .n_rst(n_rst), .mode(mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack2), .tx_data(tx_data2), .tx_push(tx_push2), .tx_full(tx_full),
    .fifo_level(fifo_level2), .drop_cnt(drop_cnt2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- UART core RX emulation ----------------
  logic [7:0] src_q[$];
  always @(posedge clk) begin
    #1;
    if (rx_ack && src_q.size() > 0) void'(src_q.pop_front());
    rx_valid = (src_q.size() > 0);
    if (src_q.size() > 0) rx_data = src_q[0];
  end

  task automatic send(input logic [7:0] w);
    src_q.push_back(w);
  endtask

  task automatic wait_src_empty();
    for (int i = 0; i < 3000 && src_q.size() > 0; i++) step(1);
    checks++;
    if (src_q.size() > 0) begin
      errors++;
      $display("FAIL src_drain actual=%0d words left required=0", src_q.size());
      src_q.delete();
    end
  endtask

  // ---------------- reference model ----------------
  logic [39:0] exp_q[$];          // {cycle, word} of each predicted TX push
  logic [7:0]  m_q[$];
  logic [7:0]  m_cap = 8'h00;
  logic [7:0]  cur_txd = 8'h00;
  bit          m_ack = 1'b0, m_prev = 1'b0, cur_ack = 1'b0;
  int          m_drop = 0, cur_level = 0, cur_drop = 0;

  function automatic logic [7:0] xform(input logic [1:0] md, input logic [7:0] w);
    if (md == 2'b01 && w >= 8'h61 && w <= 8'h7A) return w - 8'h20;
    return w;
  endfunction

  always @(negedge clk) begin
    if (!n_rst) begin
      m_q.delete();
      exp_q.delete();
      m_ack = 0; m_prev = 0; m_drop = 0; m_cap = 8'h00; cur_txd = 8'h00;
      cur_level = 0; cur_drop = 0; cur_ack = 0;
    end else begin
      int  n_terms;
      bit  drain, pop, full_before;
      logic [7:0] w;
      cur_level = m_q.size();
      cur_drop  = m_drop;
      cur_ack   = m_ack;
      n_terms = 0;
      foreach (m_q[i]) if (m_q[i] == 8'h0D) n_terms++;
      drain       = (mode == 2'b10) ? (n_terms > 0 || m_q.size() == DEPTH) : 1'b1;
      full_before = (m_q.size() == DEPTH);
      pop         = (m_q.size() > 0) && !tx_full && !m_prev && drain;
      if (pop) begin
        w = m_q.pop_front();
        exp_q.push_back({cyc[31:0], w});
        cur_txd = w;
      end
      if (m_ack && mode != 2'b11) begin
        if (full_before && !pop) m_drop++;
        else m_q.push_back(xform(mode, m_cap));
      end
      m_prev = pop;
      if (!m_ack && rx_valid) begin
        m_cap = rx_data;
        m_ack = 1;
      end else begin
        m_ack = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    #1;
    if (n_rst) begin
      logic [39:0] e;
      while (exp_q.size() > 0 && int'(exp_q[0][39:8]) < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missed_push actual=none required=%0h at cycle %0d", e[7:0], e[39:8]);
      end
      if (tx_push) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_push actual=%0h required=no push cycle=%0d", tx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("push_cycle", cyc, e[39:8]);
        end
      end
      check("tx_data", {24'h0, tx_data}, {24'h0, cur_txd});
      check("rx_ack", {31'h0, rx_ack}, {31'h0, cur_ack});
      check("fifo_level", {{(32-LW){1'b0}}, fifo_level}, cur_level);
      check("drop_cnt", {16'h0, drop_cnt}, cur_drop);
      check("drop_sat", {30'h0, drop_cnt2}, (cur_drop > 3) ? 3 : cur_drop);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ack", {31'h0, rx_ack}, 0);
    check("rst_tx_push", {31'h0, tx_push}, 0);
    check("rst_tx_data", {24'h0, tx_data}, 0);
    check("rst_level", {{(32-LW){1'b0}}, fifo_level}, 0);
    check("rst_drop", {16'h0, drop_cnt}, 0);
    n_rst = 1'b1;
    step(5);

    // echo, upper-case, then line mode holding until CR
    mode = 2'b00; send(8'h41); wait_src_empty(); step(10);
    mode = 2'b01; send(8'h61); send(8'h5A); send(8'h7B); wait_src_empty(); step(10);
    mode = 2'b10; send(8'h68); send(8'h69); wait_src_empty(); step(20);
    check("line_held", {{(32-LW){1'b0}}, fifo_level}, 2);
    send(8'h0D); wait_src_empty(); step(12);
    check("line_released", {{(32-LW){1'b0}}, fifo_level}, 0);

    // overflow with TX blocked
    mode = 2'b00; tx_full = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(8'h30 + i));
    wait_src_empty(); step(4);
    check("ovf_level", {{(32-LW){1'b0}}, fifo_level}, 16);
    check("ovf_drop", {16'h0, drop_cnt}, 4);
    check("ovf_drop_sat", {30'h0, drop_cnt2}, 3);
    tx_full = 1'b0; step(40);

    // random traffic, modes and backpressure
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      tx_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0 && src_q.size() < 4) begin
        case ($urandom_range(0, 3))
          0:       send(8'h0D);
          1:       send(8'($urandom_range(8'h61, 8'h7A)));
          default: send(8'($urandom_range(0, 255)));
        endcase
      end
      step(1);
    end
    mode = 2'b00; tx_full = 1'b0;
    wait_src_empty(); step(60);
    check("drain_level", {{(32-LW){1'b0}}, fifo_level}, 0);

    // reset while a push is in flight
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i));
    wait_src_empty(); step(4);
    check("pre_rst_level", {{(32-LW){1'b0}}, fifo_level}, 5);
    tx_full = 1'b0;
    #2;
    check("pre_rst_push", {31'h0, tx_push}, 1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_push", {31'h0, tx_push}, 0);
    check("mid_rst_data", {24'h0, tx_data}, 0);
    check("mid_rst_level", {{(32-LW){1'b0}}, fifo_level}, 0);
    check("mid_rst_drop", {16'h0, drop_cnt}, 0);
    check("mid_rst_ack", {31'h0, rx_ack}, 0);
    src_q.delete();
    step(3);
    n_rst = 1'b1;
    step(20);
    check("post_rst_level", {{(32-LW){1'b0}}, fifo_level}, 0);
    check("exp_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
